// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time, holds the fetched
// instruction for IF/ID until it advances, and squashes in-flight work on a redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        FetchValidF,
  output logic        BusyF
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_AL  = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] RESET_PC_P4  = RESET_PC_AL + PC_STEP;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] seq_pc_c;

  // Redirect targets are word aligned; the adder wraps naturally at 2^32.
  assign target_c = {PCTargetE[XLEN-1:2], 2'b00};
  assign seq_pc_c = fetch_pc_q + PC_STEP;

  // Next-state, datapath and request strobe; redirect outranks stall and response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pcf_d      = pcf_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;

    case (state_q)
      S_ISSUE: begin
        imem_req = 1'b1;
        if (PCSrcE) begin
          fetch_pc_d = target_c;
          state_d    = S_DROP;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          fetch_pc_d = target_c;
          state_d    = imem_valid ? S_ISSUE : S_DROP;
        end else if (imem_valid) begin
          instr_d = imem_rdata;
          pcf_d   = fetch_pc_q;
          pcp4_d  = seq_pc_c;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          fetch_pc_d = target_c;
          valid_d    = 1'b0;
          instr_d    = '0;
          state_d    = S_ISSUE;
        end else if (!StallF) begin
          fetch_pc_d = seq_pc_c;
          valid_d    = 1'b0;
          instr_d    = '0;
          state_d    = S_ISSUE;
        end
      end
      S_DROP: begin
        // A response consumed here belongs to a squashed request.
        if (PCSrcE) begin
          fetch_pc_d = target_c;
        end
        if (imem_valid) begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_ISSUE;
      fetch_pc_q <= RESET_PC_AL;
      instr_q    <= '0;
      pcf_q      <= RESET_PC_AL;
      pcp4_q     <= RESET_PC_P4;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pcf_q      <= pcf_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrF      = instr_q;
  assign PCF         = pcf_q;
  assign PCplus4F    = pcp4_q;
  assign FetchValidF = valid_q;
  assign BusyF       = ~valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios pinned with literal values, then a long
// randomized run against a transaction-level fetch model with a variable-latency memory.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall, pcsrc, ivalid, ireq, fv, busy;
  logic [31:0] target, iaddr, irdata, instr, pcf, pcp4;
  logic        stall2, pcsrc2, ivalid2, ireq2, fv2, busy2;
  logic [31:0] target2, iaddr2, irdata2, instr2, pcf2, pcp42;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .StallF(stall), .PCSrcE(pcsrc), .PCTargetE(target),
    .imem_req(ireq), .imem_addr(iaddr), .imem_valid(ivalid), .imem_rdata(irdata),
    .InstrF(instr), .PCF(pcf), .PCplus4F(pcp4), .FetchValidF(fv), .BusyF(busy)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .StallF(stall2), .PCSrcE(pcsrc2), .PCTargetE(target2),
    .imem_req(ireq2), .imem_addr(iaddr2), .imem_valid(ivalid2), .imem_rdata(irdata2),
    .InstrF(instr2), .PCF(pcf2), .PCplus4F(pcp42), .FetchValidF(fv2), .BusyF(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  int          lat_fix = 1;
  int          stall_pct = 0, redir_pct = 0, stray_pct = 0;
  int          force_stall = 0;
  bit          force_redir = 1'b0, force_stray = 1'b0;
  logic [31:0] force_tgt = 32'h0;

  // Reference model: one request in flight, maybe marked for discard, or a held instruction.
  logic [31:0] m_pc, m_instr, m_pcf, m_pcp4;
  bit          m_outst, m_discard, m_fv;

  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          pend2 = 1'b0;
  logic [31:0] pend2_addr = 32'h0;
  logic [31:0] addr_log[$];
  logic [31:0] addr_log2[$];
  int          fv_rises = 0;
  bit          fv_prev = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      1:       return $urandom & 32'h3FF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcf = 32'h0; m_pcp4 = 32'h4;
    m_outst = 1'b0; m_discard = 1'b0; m_fv = 1'b0;
    mem_cnt = 0; pend2 = 1'b0; fv_prev = 1'b0;
  endtask

  // One clock: compare at the falling edge, choose and drive inputs, advance the model.
  task automatic cycle();
    bit          v, r, s, issuing;
    logic [31:0] d, t;
    @(negedge clk);
    issuing = !m_outst && !m_fv;
    chk("imem_req", 32'(ireq), 32'(issuing));
    if (issuing) chk("imem_addr", iaddr, m_pc);
    chk("InstrF", instr, m_fv ? m_instr : 32'h0);
    chk("PCF", pcf, m_pcf);
    chk("PCplus4F", pcp4, m_pcp4);
    chk("FetchValidF", 32'(fv), 32'(m_fv));
    chk("BusyF", 32'(busy), 32'(!m_fv));
    if (ireq) addr_log.push_back(iaddr);
    if (ireq2) addr_log2.push_back(iaddr2);
    if (fv && !fv_prev) fv_rises++;
    fv_prev = fv;

    v = 1'b0;
    d = $urandom;
    if (mem_cnt != 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        v = 1'b1;
        d = mem_data(mem_addr);
      end
    end else if (force_stray || ($urandom_range(99) < stray_pct)) begin
      v = 1'b1;
    end
    r = force_redir || ($urandom_range(99) < redir_pct);
    if (v && m_outst && m_discard) r = 1'b0;
    t = force_redir ? force_tgt : rand_target();
    s = (force_stall >= 0) ? force_stall[0] : ($urandom_range(99) < stall_pct);
    if (issuing) begin
      mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(3, 1));
      mem_addr = m_pc;
    end

    stall = s; pcsrc = r; target = t; ivalid = v; irdata = d;
    ivalid2 = pend2; irdata2 = mem_data(pend2_addr) ^ 32'h5A5A_5A5A;
    pend2 = ireq2; pend2_addr = iaddr2;

    if (issuing) begin
      m_outst = 1'b1;
      m_discard = r;
      if (r) m_pc = align(t);
    end else if (m_outst) begin
      if (r) begin
        m_pc = align(t);
        if (v) begin m_outst = 1'b0; m_discard = 1'b0; end
        else m_discard = 1'b1;
      end else if (v) begin
        if (!m_discard) begin
          m_instr = d; m_pcf = m_pc; m_pcp4 = m_pc + 32'd4; m_fv = 1'b1;
        end
        m_outst = 1'b0; m_discard = 1'b0;
      end
    end else begin
      if (r) begin m_fv = 1'b0; m_pc = align(t); end
      else if (!s) begin m_fv = 1'b0; m_pc = m_pc + 32'd4; end
    end
    @(posedge clk);
  endtask

  task automatic drive_idle();
    stall = 1'b0; pcsrc = 1'b0; target = 32'h0; ivalid = 1'b0; irdata = 32'h0;
    ivalid2 = 1'b0; irdata2 = 32'h0;
  endtask

  initial begin
    stall2 = 1'b0; pcsrc2 = 1'b0; target2 = 32'h0;
    drive_idle();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst PCF", pcf, 32'h0);
    chk("rst PCplus4F", pcp4, 32'h4);
    chk("rst InstrF", instr, 32'h0);
    chk("rst BusyF", 32'(busy), 32'h1);
    chk("rst imem_addr", iaddr, 32'h0);
    chk("wrap rst PCF", pcf2, 32'hFFFF_FFFC);
    chk("wrap rst PCplus4F", pcp42, 32'h0);
    chk("wrap rst imem_addr", iaddr2, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Streaming with a 1-cycle memory and no stalls.
    lat_fix = 1; force_stall = 0;
    repeat (2) cycle();
    #1;
    chk("wrap held PCF", pcf2, 32'hFFFF_FFFC);
    chk("wrap held PCplus4F", pcp42, 32'h0);
    chk("wrap FetchValidF", 32'(fv2), 32'h1);
    repeat (6) cycle();
    #1;
    chk("wrap 2nd addr", addr_log2.size() > 1 ? addr_log2[1] : 32'hDEAD_BEEF, 32'h0);
    chk("seq log size", 32'(addr_log.size()), 32'd3);
    chk("seq addr0", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("seq addr1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("seq addr2", addr_log.size() > 2 ? addr_log[2] : 32'hDEAD_BEEF, 32'h8);

    // Stall while holding PC 8.
    force_stall = 1;
    repeat (3) begin
      cycle();
      #1;
      chk("stall PCF", pcf, 32'h8);
      chk("stall PCplus4F", pcp4, 32'hC);
      chk("stall InstrF", instr, mem_data(32'h8));
      chk("stall imem_req", 32'(ireq), 32'h0);
    end
    chk("fv pulses", 32'(fv_rises), 32'd3);
    force_stall = 0;
    cycle();
    #1;
    chk("after stall req", 32'(ireq), 32'h1);
    chk("after stall addr", iaddr, 32'hC);

    // Redirect while waiting on a 3-cycle memory.
    lat_fix = 3;
    cycle();
    force_redir = 1'b1; force_tgt = 32'h100;
    cycle();
    force_redir = 1'b0;
    repeat (2) begin
      cycle();
      #1;
      chk("drop FetchValidF", 32'(fv), 32'h0);
      chk("drop InstrF", instr, 32'h0);
    end
    chk("redir req", 32'(ireq), 32'h1);
    chk("redir addr", iaddr, 32'h100);

    // Redirect in the same cycle as the response; target low bits ignored.
    lat_fix = 1;
    cycle();
    force_redir = 1'b1; force_tgt = 32'h203;
    cycle();
    force_redir = 1'b0;
    #1;
    chk("same-cycle addr", iaddr, 32'h200);
    chk("same-cycle FetchValidF", 32'(fv), 32'h0);

    // Reset while a request is outstanding.
    lat_fix = 2;
    repeat (2) cycle();
    #2 reset = 1'b1;
    #1;
    chk("mid rst PCF", pcf, 32'h0);
    chk("mid rst PCplus4F", pcp4, 32'h4);
    chk("mid rst FetchValidF", 32'(fv), 32'h0);
    chk("mid rst imem_addr", iaddr, 32'h0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lat_fix = 1; force_stray = 1'b1;
    cycle();
    force_stray = 1'b0;
    cycle();
    #1;
    chk("post rst PCF", pcf, 32'h0);
    chk("post rst InstrF", instr, mem_data(32'h0));

    // Randomized traffic.
    force_stall = -1; lat_fix = 0;
    stall_pct = 40; redir_pct = 10; stray_pct = 15;
    repeat (3000) cycle();
    stall_pct = 5; redir_pct = 30; stray_pct = 30;
    repeat (2000) cycle();
    stall_pct = 80; redir_pct = 3; stray_pct = 5;
    repeat (2000) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
